// File: rtl/ser_frame_pkg.sv
// Shared definitions for the serial frame receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ser_frame_pkg;

  // Receiver FSM encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Line levels that frame each word
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/ser_frame_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, optional even parity, stop.
// Latency: word is presented the cycle after the stop-bit sample.
// Backpressure: one-word holding register; a frame completing while it is full and not being accepted is dropped (ovr_err).
module ser_frame_rx
  import ser_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              ser_vld,
  output logic [DATA_W-1:0] data_out,
  output logic              data_vld,
  input  logic              data_rdy,
  output logic              par_err,
  output logic              frm_err,
  output logic              ovr_err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] word;
  logic              par_pend;
  logic              frame_done;
  logic              frame_bad;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and end-of-frame decode; only a valid sample advances the FSM
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    if (ser_vld) begin
      case (state)
        IDLE: begin
          if (ser_in == START_BIT) state_nxt = DATA;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN) state_nxt = PARITY;
            else           state_nxt = STOP;
          end
        end
        PARITY: begin
          state_nxt = STOP;
        end
        STOP: begin
          // A bad stop bit returns to IDLE without being reused as a start bit
          state_nxt = IDLE;
          if (ser_in == STOP_BIT) frame_done = 1'b1;
          else                    frame_bad  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bit counter, word assembly and parity check; counter saturates at the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      word     <= '0;
      par_pend <= 1'b0;
    end else if (ser_vld) begin
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          par_pend <= 1'b0;
        end
        DATA: begin
          word[bit_cnt] <= ser_in;
          if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + CNT_W'(1);
        end
        PARITY: begin
          // Even parity: the received bit must equal the XOR of the data bits
          par_pend <= ser_in ^ (^word);
        end
        default: ;
      endcase
    end
  end

  // Holding register with valid/ready handshake and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      data_vld <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      frm_err <= frame_bad;
      ovr_err <= 1'b0;
      if (frame_done && (!data_vld || data_rdy)) begin
        // Empty, or the held word leaves this same cycle: load the new one
        data_out <= word;
        par_err  <= par_pend;
        data_vld <= 1'b1;
      end else begin
        if (frame_done)           ovr_err  <= 1'b1;
        if (data_vld && data_rdy) data_vld <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ser_frame_rx.md
SER_FRAME_RX -- requirements
Module: ser_frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 2..16).
REQ-002 SHALL have parameter PARITY_EN, default 1, 1 = even parity bit present, 0 = no parity bit.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ser_in  input  1  serial bit stream, LSB-first, driven by the upstream shift register's right serial output.
REQ-006 SHALL have port ser_vld  input  1  ser_in carries a valid bit this cycle (high while upstream shifts right).
REQ-007 SHALL have port data_out  output  DATA_W  received word.
REQ-008 SHALL have port data_vld  output  1  data_out/par_err valid.
REQ-009 SHALL have port data_rdy  input  1  consumer accepts word when data_vld && data_rdy.
REQ-010 SHALL have port par_err  output  1  parity mismatch flag for the word on data_out.
REQ-011 SHALL have port frm_err  output  1  one-cycle pulse: bad stop bit, frame dropped.
REQ-012 SHALL have port ovr_err  output  1  one-cycle pulse: completed frame dropped, holding register full.

Function
REQ-013 SHALL sample ser_in only on cycles with ser_vld=1; cycles with ser_vld=0 SHALL change no state.
REQ-014 Frame format SHALL be: start bit 1, DATA_W data bits LSB first, parity bit if PARITY_EN, stop bit 0.
REQ-015 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: a sampled 1 -> DATA with bit counter cleared; a sampled 0 -> stay in IDLE.
REQ-017 DATA: each sample shifts into the word at the bit-counter position; after bit DATA_W-1 -> PARITY if PARITY_EN=1, else STOP.
REQ-018 PARITY: the sample is compared with the XOR of the data bits; a mismatch sets the pending par_err; -> STOP.
REQ-019 STOP: sample 0 -> frame complete, -> IDLE; sample 1 -> frm_err pulse next cycle, frame discarded, -> IDLE; this 1 SHALL NOT be taken as a start bit.
REQ-020 A completed frame SHALL load data_out/par_err and assert data_vld on the cycle after the stop-bit sample.
REQ-021 data_vld SHALL stay high, with data_out/par_err stable, until data_vld && data_rdy; it deasserts the next cycle unless a new word loads in that same cycle.
REQ-022 If a frame completes while data_vld=1 and data_rdy=0, the frame SHALL be dropped, ovr_err pulses for one cycle, and the held word is unchanged.
REQ-023 If a frame completes in the same cycle the held word is accepted, the new word SHALL load with no ovr_err and data_vld stays high.
REQ-024 The bit counter SHALL be $clog2(DATA_W) bits and SHALL never wrap within a frame.
REQ-025 The receiver SHALL accept back-to-back frames with zero idle samples between stop and the next start bit.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, counter=0, data_out=0, data_vld=0, par_err=0, frm_err=0, ovr_err=0.
REQ-027 rst asserted mid-frame SHALL discard the partial frame with no error pulse; reception resumes at the next start bit after release.
REQ-028 rst SHALL take priority over ser_vld and data_rdy.

Structure
REQ-029 The FSM state encoding and the START_BIT=1 and STOP_BIT=0 constants SHALL live in shared package ser_frame_pkg.
REQ-030 The block SHALL be a single module with no sub-module; the holding register is inline.
REQ-031 All outputs SHALL be registered, with no combinational path from ser_in or data_rdy to any output.

Verification
REQ-032 Bench SHALL cover: serial bits 1,1,0,1,0,0,1,0,1,0,0 with ser_vld=1 and data_rdy=1 -> data_out=0xA5, par_err=0, data_vld high for 1 cycle, 1 cycle after the last bit.
REQ-033 Bench SHALL cover: 0xA5 sent with parity bit 1 -> data_out=0xA5, par_err=1.
REQ-034 Bench SHALL cover: 0x3C sent with stop bit 1 -> frm_err pulse, no data_vld; a following 0x81 frame is received correctly.
REQ-035 Bench SHALL cover: data_rdy=0, two frames 0x11 then 0x22 -> data_out remains 0x11 and ovr_err pulses once; with data_rdy asserted on the 0x22 completion cycle instead -> 0x22 loads with no ovr_err.
REQ-036 Bench SHALL cover: rst asserted after 4 data bits, then a full 0x5A frame -> outputs 0 during reset, then data_out=0x5A.
REQ-037 Bench SHALL cover: 0xA5 with ser_vld toggling 1/0 every cycle -> same result as REQ-032, with latency doubled.
